fft_tx_sequencer: RTL and testbench

FFT_TX_SEQUENCER -- requirements
Module: fft_tx_sequencer

---
 rtl/fft_tx_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fft_tx_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_tx_sequencer.sv
// fft_tx_sequencer: captures one frame of FFT real-part words and streams it
// byte by byte to a UART transmitter, low byte of each word first.
// Optional feature: define FFT_TX_HEADER_EN to prefix every frame with the
// sync byte 8'hA5 (frame becomes 2*FFT_SIZE+1 bytes, timing unchanged).
// Byte k of the frame is bits [8k+7:8k] of the captured vector, which is the
// same as word k/2, low byte for even k and high byte for odd k, because a
// word is exactly two bytes wide.

module fft_tx_sequencer #(
   parameter int FFT_SIZE    = 32,
   parameter int WORD_SIZE   = 16,
   parameter int DATA_LENGTH = 8
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_fft_done,
   input  logic [FFT_SIZE*WORD_SIZE-1:0]   i_fft_data,
   input  logic                            i_tx_done,
   output logic                            o_tx_start,
   output logic [DATA_LENGTH-1:0]          o_tx_byte,
   output logic                            o_busy,
   output logic                            o_frame_done,
   output logic                            o_overrun
);

   // Index space is 7 bits, so the byte mux is padded out to 128 entries.
   localparam int         NUM_BYTES = 2 * FFT_SIZE;
   localparam int         IDX_SLOTS = 128;
   localparam logic [6:0] LAST_IDX  = 7'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_FINISH    = 2'd3
   } state_t;

   state_t                          r_state;
   state_t                          w_state_next;
   logic [FFT_SIZE*WORD_SIZE-1:0]   r_buf;
   logic [6:0]                      r_idx;
   logic [DATA_LENGTH-1:0]          r_tx_byte;
   logic                            r_overrun;

   logic                            w_capture;
   logic                            w_tx_ack;
   logic                            w_last;
   logic                            w_hdr_pend;
   logic [6:0]                      w_idx_inc;
   logic [DATA_LENGTH-1:0]          w_first_byte;
   logic [DATA_LENGTH-1:0]          w_next_byte;
   logic [DATA_LENGTH-1:0]          w_byte_sel [0:IDX_SLOTS-1];

   // A new frame is only accepted from IDLE; tx_done only counts while waiting.
   assign w_capture = (r_state == S_IDLE) && i_fft_done;
   assign w_tx_ack  = (r_state == S_WAIT_DONE) && i_tx_done;
   assign w_idx_inc = r_idx + 7'd1;
   assign w_last    = !w_hdr_pend && (r_idx == LAST_IDX);

   // Byte view of the captured frame; slots beyond the frame read as zero.
   generate
      for (genvar gi = 0; gi < IDX_SLOTS; gi++) begin : g_byte_sel
         if (gi < NUM_BYTES) begin : g_used
            assign w_byte_sel[gi] = r_buf[gi*DATA_LENGTH +: DATA_LENGTH];
         end else begin : g_pad
            assign w_byte_sel[gi] = '0;
         end
      end
   endgenerate

`ifdef FFT_TX_HEADER_EN
   localparam logic [DATA_LENGTH-1:0] SYNC_BYTE = DATA_LENGTH'(8'hA5);

   logic r_hdr_pend;

   // Header pending from capture until the sync byte has been acknowledged.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_hdr_pend <= 1'b0;
      end else if (w_capture) begin
         r_hdr_pend <= 1'b1;
      end else if (w_tx_ack) begin
         r_hdr_pend <= 1'b0;
      end
   end

   assign w_hdr_pend   = r_hdr_pend;
   assign w_first_byte = SYNC_BYTE;
`else
   assign w_hdr_pend   = 1'b0;
   assign w_first_byte = i_fft_data[DATA_LENGTH-1:0];
`endif

   // After the header the index stays at 0 so data byte 0 goes next.
   assign w_next_byte = w_hdr_pend ? w_byte_sel[0] : w_byte_sel[w_idx_inc];

   // State register.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      w_state_next = r_state;
      o_tx_start   = 1'b0;
      o_busy       = 1'b1;
      o_frame_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_fft_done) begin
               w_state_next = S_START;
            end
         end
         S_START: begin
            o_tx_start   = 1'b1;
            w_state_next = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (i_tx_done) begin
               w_state_next = w_last ? S_FINISH : S_START;
            end
         end
         S_FINISH: begin
            o_frame_done = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Frame buffer: contents only matter while busy, so no reset is needed.
   always_ff @(posedge i_clk) begin
      if (w_capture) begin
         r_buf <= i_fft_data;
      end
   end

   // Byte index: cleared on capture and when returning to IDLE.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_idx <= 7'd0;
      end else if (w_capture) begin
         r_idx <= 7'd0;
      end else if (w_tx_ack && !w_last && !w_hdr_pend) begin
         r_idx <= w_idx_inc;
      end else if (r_state == S_FINISH) begin
         r_idx <= 7'd0;
      end
   end

   // Outgoing byte is loaded one edge ahead of each START and held until the
   // next acknowledge; the first byte comes straight from the input frame.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_tx_byte <= '0;
      end else if (w_capture) begin
         r_tx_byte <= w_first_byte;
      end else if (w_tx_ack && !w_last) begin
         r_tx_byte <= w_next_byte;
      end
   end

   // Sticky overrun: any frame offered while not idle is dropped and flagged.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_overrun <= 1'b0;
      end else if (i_fft_done && (r_state != S_IDLE)) begin
         r_overrun <= 1'b1;
      end
   end

   assign o_tx_byte = r_tx_byte;
   assign o_overrun = r_overrun;

endmodule

// File: tb/tb_fft_tx_sequencer.sv
// Testbench for fft_tx_sequencer: random and patterned frames, checked
// against a word/byte level model of the expected UART byte stream.
// Honours FFT_TX_HEADER_EN in the same way as the design.

module tb_fft_tx_sequencer;

   localparam int FFT  = 32;
   localparam int WORD = 16;
   localparam int DL   = 8;
   localparam int FW   = FFT * WORD;

   logic          i_clk;
   logic          i_rst;
   logic          i_fft_done;
   logic [FW-1:0] i_fft_data;
   logic          i_tx_done;
   logic          o_tx_start;
   logic [DL-1:0] o_tx_byte;
   logic          o_busy;
   logic          o_frame_done;
   logic          o_overrun;

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;
   int fdone_cnt = 0;
   logic [7:0] exp_q[$];

   fft_tx_sequencer #(
      .FFT_SIZE(FFT), .WORD_SIZE(WORD), .DATA_LENGTH(DL)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_fft_done(i_fft_done),
      .i_fft_data(i_fft_data), .i_tx_done(i_tx_done),
      .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte), .o_busy(o_busy),
      .o_frame_done(o_frame_done), .o_overrun(o_overrun)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge i_clk) begin
      if (o_tx_start === 1'b1) start_cnt <= start_cnt + 1;
      if (o_frame_done === 1'b1) fdone_cnt <= fdone_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(negedge i_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference stream: optional sync byte, then for each word low byte, high byte.
   task automatic build_exp(input logic [FW-1:0] d);
      exp_q.delete();
`ifdef FFT_TX_HEADER_EN
      exp_q.push_back(8'hA5);
`endif
      for (int k = 0; k < 2 * FFT; k++) begin
         logic [15:0] w;
         w = d[WORD*(k/2) +: WORD];
         exp_q.push_back((k % 2 == 1) ? w[15:8] : w[7:0]);
      end
   endtask

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] r;
      r = '0;
      for (int j = 0; j < FFT; j++) r[WORD*j +: WORD] = 16'($urandom);
      return r;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx_start"},   32'(o_tx_start),   32'd0);
      chk({tag, "_busy"},       32'(o_busy),       32'd0);
      chk({tag, "_frame_done"}, 32'(o_frame_done), 32'd0);
      chk({tag, "_overrun"},    32'(o_overrun),    32'd0);
      chk({tag, "_tx_byte"},    32'(o_tx_byte),    32'd0);
   endtask

   // One frame: capture, answer each start with tx_done ~10 cycles later,
   // with optional disturbances at chosen byte positions (-1 = none).
   task automatic run_frame(input logic [FW-1:0] data, input bit clobber,
                            input int again_at, input bit coincide,
                            input int reset_at, input int spur_at);
      int s0, f0, n, w;
      build_exp(data);
      n  = exp_q.size();
      s0 = start_cnt;
      f0 = fdone_cnt;
      i_fft_data = data;
      i_fft_done = 1'b1;
      tick;
      i_fft_done = 1'b0;
      if (clobber) i_fft_data = '1;
      chk("busy_after_capture", 32'(o_busy), 32'd1);
      for (int k = 0; k < n; k++) begin
         w = 0;
         while (o_tx_start !== 1'b1 && w < 40) begin
            tick;
            w++;
         end
         if (w >= 40) begin
            chk($sformatf("start_timeout_byte%0d", k), 32'(o_tx_start), 32'd1);
            return;
         end
         chk($sformatf("byte%0d", k), 32'(o_tx_byte), 32'(exp_q[k]));
         if (k == spur_at) begin
            i_tx_done = 1'b1;
            tick;
            i_tx_done = 1'b0;
         end else begin
            tick;
         end
         if (k == again_at) begin
            i_fft_done = 1'b1;
            i_fft_data = rand_frame();
            tick;
            i_fft_done = 1'b0;
            chk("overrun_set", 32'(o_overrun), 32'd1);
         end
         if (k == reset_at) begin
            tick;
            i_rst = 1'b0;
            #1;
            chk_reset_outputs("midframe_reset");
            tick;
            tick;
            chk("reset_no_frame_done", 32'(fdone_cnt - f0), 32'd0);
            chk("reset_start_count", 32'(start_cnt - s0), 32'(k + 1));
            i_rst = 1'b1;
            repeat (10) tick;
            chk("after_reset_no_start", 32'(start_cnt - s0), 32'(k + 1));
            chk("after_reset_busy", 32'(o_busy), 32'd0);
            return;
         end
         repeat (8) tick;
         chk($sformatf("hold%0d", k), 32'(o_tx_byte), 32'(exp_q[k]));
         i_tx_done = 1'b1;
         if (coincide && k == n - 1) i_fft_done = 1'b1;
         tick;
         i_tx_done  = 1'b0;
         i_fft_done = 1'b0;
      end
      chk("frame_done_pulse", 32'(o_frame_done), 32'd1);
      chk("busy_in_finish", 32'(o_busy), 32'd1);
      tick;
      chk("frame_done_low", 32'(o_frame_done), 32'd0);
      chk("busy_low_after", 32'(o_busy), 32'd0);
      chk("start_count", 32'(start_cnt - s0), 32'(n));
      chk("frame_done_count", 32'(fdone_cnt - f0), 32'd1);
      if (coincide) begin
         chk("coincide_overrun", 32'(o_overrun), 32'd1);
         repeat (6) tick;
         chk("coincide_no_new_frame", 32'(start_cnt - s0), 32'(n));
         chk("coincide_idle", 32'(o_busy), 32'd0);
      end
   endtask

   initial begin
      logic [FW-1:0] pat;
      i_rst      = 1'b0;
      i_fft_done = 1'b0;
      i_tx_done  = 1'b0;
      i_fft_data = '0;
      repeat (3) tick;
      chk_reset_outputs("reset_state");
      i_rst = 1'b1;
      tick;

      // Stray tx_done while idle must not start anything.
      i_tx_done = 1'b1;
      tick;
      i_tx_done = 1'b0;
      repeat (5) tick;
      chk("idle_spurious_start", 32'(start_cnt), 32'd0);
      chk("idle_spurious_busy", 32'(o_busy), 32'd0);

      // Patterned frame 0x0100+j, stray tx_done during START of byte 3.
      for (int j = 0; j < FFT; j++) pat[WORD*j +: WORD] = 16'h0100 + 16'(j);
      run_frame(pat, 1'b0, -1, 1'b0, -1, 3);

      // Input changes right after capture must not leak into the stream.
      run_frame(rand_frame(), 1'b1, -1, 1'b0, -1, -1);

      // New frame coinciding with the final tx_done is dropped.
      chk("ovr_clear_before", 32'(o_overrun), 32'd0);
      run_frame(rand_frame(), 1'b0, -1, 1'b1, -1, -1);

      // Reset at byte 20 aborts and clears overrun.
      run_frame(rand_frame(), 1'b0, -1, 1'b0, 20, -1);
      chk("ovr_cleared_by_reset", 32'(o_overrun), 32'd0);

      // Fresh frame from byte 0 with a second fft_done at byte 5.
      run_frame(rand_frame(), 1'b0, 5, 1'b0, -1, 17);

      // Overrun stays set across a clean frame.
      run_frame(rand_frame(), 1'b0, -1, 1'b0, -1, -1);
      chk("ovr_sticky", 32'(o_overrun), 32'd1);

      i_rst = 1'b0;
      tick;
      chk("ovr_final_reset", 32'(o_overrun), 32'd0);
      i_rst = 1'b1;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
